uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 18 +
 rtl/tx_baud_counter.sv | 46 ++++
 rtl/uart_tx_engine.sv | 129 ++++++++++++
 tb/tb_uart_tx_engine.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line levels, used by the transmitter and receiver.
// Latency: none (constants only).
// Backpressure: not applicable.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Idle line and stop bit share the same level; the start bit is its inverse.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/tx_baud_counter.sv
// Bit timing for the UART transmitter: edge counter per bit period and data bit counter.
// Latency: bit_done is combinational from the edge counter; counters update on Tx_CLK.
// Backpressure: none; counts freely while enabled, clears when disabled.
module tx_baud_counter #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5,
  localparam int BIT_CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                      Tx_CLK,
  input  logic                      Tx_RST,
  input  logic                      enable,
  input  logic                      bit_en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]      bit_cnt,
  output logic                      bit_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  // The final cycle of a bit period is the one where the edge count reaches the prescale value.
  assign bit_done = enable && (edge_cnt == prescale);

  // Edge counter: runs 0..prescale while enabled, so each bit lasts prescale+1 cycles.
  always_ff @(posedge Tx_CLK or posedge Tx_RST) begin
    if (Tx_RST) begin
      edge_cnt <= '0;
    end else if (!enable || bit_done) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  // Bit counter: advances once per finished data bit and wraps back to 0 after the last one.
  always_ff @(posedge Tx_CLK or posedge Tx_RST) begin
    if (Tx_RST) begin
      bit_cnt <= '0;
    end else if (!enable) begin
      bit_cnt <= '0;
    end else if (bit_en && bit_done) begin
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: captures a payload on request and serializes start, data (LSB first), optional parity, stop.
// Latency: start bit appears on Tx_OUT the cycle after accept; frame is (prescale+1)*(DATA_WIDTH+2+PAR_EN) cycles.
// Backpressure: requests are taken only in IDLE; Tx_Data_Valid while busy is dropped, not queued.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      Tx_CLK,
  input  logic                      Tx_RST,
  input  logic [DATA_WIDTH-1:0]     Tx_P_DATA,
  input  logic                      Tx_Data_Valid,
  input  logic                      Tx_PAR_EN,
  input  logic                      Tx_PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Tx_prescale,
  output logic                      Tx_OUT,
  output logic                      Tx_Busy
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  uart_state_t               state_q;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;

  logic                      cnt_en;
  logic                      bit_en;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic                      bit_done;
  logic                      unused_edge_cnt;

  // Timing runs for the whole frame; the bit counter only matters while sending payload bits.
  assign cnt_en = (state_q != ST_IDLE);
  assign bit_en = (state_q == ST_DATA);

  tx_baud_counter #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_baud (
    .Tx_CLK   (Tx_CLK),
    .Tx_RST   (Tx_RST),
    .enable   (cnt_en),
    .bit_en   (bit_en),
    .prescale (prescale_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_done (bit_done)
  );

  // Edge count is exposed by the counter for observation only; the FSM keys off bit_done.
  assign unused_edge_cnt = ^edge_cnt;

  // Frame FSM and serializer: Tx_OUT is loaded with the next bit's level on each bit boundary.
  // The payload sits in a right-shifting register so the line always takes bit 0.
  // Parity is folded into a single bit at accept time so later input changes cannot affect it.
  always_ff @(posedge Tx_CLK or posedge Tx_RST) begin
    if (Tx_RST) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      prescale_q <= '0;
      Tx_OUT     <= LINE_IDLE;
      Tx_Busy    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          Tx_OUT  <= LINE_IDLE;
          Tx_Busy <= 1'b0;
          if (Tx_Data_Valid) begin
            shift_q    <= Tx_P_DATA;
            par_en_q   <= Tx_PAR_EN;
            par_bit_q  <= (^Tx_P_DATA) ^ Tx_PAR_TYP;
            prescale_q <= Tx_prescale;
            state_q    <= ST_START;
            Tx_OUT     <= LINE_START;
            Tx_Busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state_q <= ST_DATA;
            Tx_OUT  <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                state_q <= ST_PARITY;
                Tx_OUT  <= par_bit_q;
              end else begin
                state_q <= ST_STOP;
                Tx_OUT  <= LINE_IDLE;
              end
            end else begin
              Tx_OUT  <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            state_q <= ST_STOP;
            Tx_OUT  <= LINE_IDLE;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            state_q <= ST_IDLE;
            Tx_Busy <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          Tx_OUT  <= LINE_IDLE;
          Tx_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed frames plus randomized frames against a line-level model.
// Latency: model expects the start bit one cycle after the accepting edge.
// Backpressure: exercises held Tx_Data_Valid and mid-frame input changes.
module tb_uart_tx_engine;

  localparam int DW = 8;
  localparam int PW = 5;

  logic          Tx_CLK = 1'b0;
  logic          Tx_RST;
  logic [DW-1:0] Tx_P_DATA;
  logic          Tx_Data_Valid;
  logic          Tx_PAR_EN;
  logic          Tx_PAR_TYP;
  logic [PW-1:0] Tx_prescale;
  logic          Tx_OUT;
  logic          Tx_Busy;

  int n_cmp = 0;
  int n_err = 0;

  // Values driven onto the inputs partway through a frame.
  logic [DW-1:0] mid_data;
  logic          mid_pe;
  logic          mid_pt;
  logic [PW-1:0] mid_ps;

  uart_tx_engine #(
    .DATA_WIDTH     (DW),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .Tx_CLK        (Tx_CLK),
    .Tx_RST        (Tx_RST),
    .Tx_P_DATA     (Tx_P_DATA),
    .Tx_Data_Valid (Tx_Data_Valid),
    .Tx_PAR_EN     (Tx_PAR_EN),
    .Tx_PAR_TYP    (Tx_PAR_TYP),
    .Tx_prescale   (Tx_prescale),
    .Tx_OUT        (Tx_OUT),
    .Tx_Busy       (Tx_Busy)
  );

  always #5 Tx_CLK = ~Tx_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request, lets it be accepted on the next edge, then checks every cycle of the
  // frame against the line sequence built from the payload, followed by one idle cycle.
  // mid_cyc >= 0 drives the mid_* values onto the inputs at that frame cycle.
  task automatic frame(input string tag, input logic [DW-1:0] d, input logic pe, input logic pt,
                       input logic [PW-1:0] ps, input bit hold, input int mid_cyc);
    logic exp_bits[$];
    int   k;
    Tx_P_DATA     = d;
    Tx_PAR_EN     = pe;
    Tx_PAR_TYP    = pt;
    Tx_prescale   = ps;
    Tx_Data_Valid = 1'b1;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
    if (pe) exp_bits.push_back((^d) ^ pt);
    exp_bits.push_back(1'b1);
    @(posedge Tx_CLK);
    #1;
    if (!hold) Tx_Data_Valid = 1'b0;
    k = 0;
    for (int b = 0; b < exp_bits.size(); b++) begin
      for (int c = 0; c <= int'(ps); c++) begin
        check({tag, "_out"}, 32'(Tx_OUT), 32'(exp_bits[b]));
        check({tag, "_busy"}, 32'(Tx_Busy), 32'd1);
        if (k == mid_cyc) begin
          Tx_P_DATA   = mid_data;
          Tx_PAR_EN   = mid_pe;
          Tx_PAR_TYP  = mid_pt;
          Tx_prescale = mid_ps;
        end
        k++;
        @(posedge Tx_CLK);
        #1;
      end
    end
    check({tag, "_idle_out"}, 32'(Tx_OUT), 32'd1);
    check({tag, "_idle_busy"}, 32'(Tx_Busy), 32'd0);
  endtask

  task automatic new_mid();
    mid_data = DW'($urandom);
    mid_pe   = 1'($urandom);
    mid_pt   = 1'($urandom);
    mid_ps   = PW'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic          pe;
    logic          pt;
    logic [PW-1:0] ps;

    Tx_RST        = 1'b1;
    Tx_Data_Valid = 1'b1;
    Tx_P_DATA     = 8'h00;
    Tx_PAR_EN     = 1'b0;
    Tx_PAR_TYP    = 1'b0;
    Tx_prescale   = '0;
    mid_data      = '0;
    mid_pe        = 1'b0;
    mid_pt        = 1'b0;
    mid_ps        = '0;

    // Held in reset with a pending request: line idle, not busy.
    repeat (3) @(posedge Tx_CLK);
    #1;
    check("rst_out", 32'(Tx_OUT), 32'd1);
    check("rst_busy", 32'(Tx_Busy), 32'd0);

    Tx_Data_Valid = 1'b0;
    Tx_RST        = 1'b0;
    repeat (3) @(posedge Tx_CLK);
    #1;
    check("idle_out", 32'(Tx_OUT), 32'd1);
    check("idle_busy", 32'(Tx_Busy), 32'd0);

    // Directed frames.
    frame("a5_nopar_p7", 8'hA5, 1'b0, 1'b0, 5'd7, 1'b0, -1);
    frame("a5_even_p3",  8'hA5, 1'b1, 1'b0, 5'd3, 1'b0, -1);
    frame("a5_odd_p3",   8'hA5, 1'b1, 1'b1, 5'd3, 1'b0, -1);
    frame("ff_even_p0",  8'hFF, 1'b1, 1'b0, 5'd0, 1'b0, -1);
    frame("81_odd_p31",  8'h81, 1'b1, 1'b1, 5'd31, 1'b0, -1);

    // Inputs changed mid-frame must not disturb the captured frame.
    new_mid();
    frame("mid_change", 8'h96, 1'b1, 1'b0, 5'd5, 1'b0, 10);

    // Request held high: the second payload offered while busy is not sent in this frame;
    // the next frame starts after one idle cycle and carries whatever is presented then.
    mid_data = 8'hC3;
    mid_pe   = 1'b0;
    mid_pt   = 1'b0;
    mid_ps   = 5'd2;
    frame("hold_3c", 8'h3C, 1'b0, 1'b0, 5'd3, 1'b1, 5);
    frame("hold_c3", 8'hC3, 1'b0, 1'b0, 5'd2, 1'b0, -1);

    // Reset during data bit 4 of a 0x06 frame (prescale 3): bit 4 is low until reset hits.
    Tx_P_DATA     = 8'h06;
    Tx_PAR_EN     = 1'b0;
    Tx_PAR_TYP    = 1'b0;
    Tx_prescale   = 5'd3;
    Tx_Data_Valid = 1'b1;
    @(posedge Tx_CLK);
    #1;
    Tx_Data_Valid = 1'b0;
    repeat (21) @(posedge Tx_CLK);
    #1;
    check("pre_rst_out", 32'(Tx_OUT), 32'd0);
    check("pre_rst_busy", 32'(Tx_Busy), 32'd1);
    Tx_RST = 1'b1;
    #1;
    check("mid_rst_out", 32'(Tx_OUT), 32'd1);
    check("mid_rst_busy", 32'(Tx_Busy), 32'd0);
    @(posedge Tx_CLK);
    #1;
    check("mid_rst_hold_out", 32'(Tx_OUT), 32'd1);
    Tx_RST = 1'b0;
    frame("after_rst_5a", 8'h5A, 1'b1, 1'b0, 5'd2, 1'b0, -1);

    // Randomized frames with a random mid-frame input disturbance.
    for (int n = 0; n < 24; n++) begin
      d  = DW'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = PW'($urandom_range(0, 6));
      new_mid();
      frame("rand", d, pe, pt, ps, 1'b0, int'($urandom_range(0, (int'(ps) + 1) * (DW + 1) - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
